// File: rtl/xnor_popcount_acc.sv
// Streaming popcount accumulator behind the XNOR stage. It sums set bits over
// WINDOW accepted beats and emits the total with a threshold decision bit.
module xnor_popcount_acc #(
    parameter int WIDTH  = 5,
    parameter int WINDOW = 4,
    parameter int THRESH = 10
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      in_vec,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [$clog2(WIDTH*WINDOW+1)-1:0]     out_sum,
    output logic                                  out_bit
);
    localparam int SUM_W = $clog2(WIDTH*WINDOW+1);
    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);

    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             final_beat;
    logic [SUM_W-1:0] pc;
    logic [SUM_W-1:0] sum_c;

    assign final_beat = (beat_cnt_q == LAST_BEAT);
    assign in_ready   = !(final_beat && out_valid_q);
    assign accept     = in_valid && in_ready;

    // Gated by accept so an undriven in_vec never reaches the accumulator.
    always_comb begin
        pc = '0;
        if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                pc = pc + SUM_W'(in_vec[i]);
            end
        end
    end

    assign sum_c = acc_q + pc;

    always_comb begin
        acc_d       = acc_q;
        beat_cnt_d  = beat_cnt_q;
        out_sum_d   = out_sum_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            acc_d      = '0;
            beat_cnt_d = '0;
        end else if (accept) begin
            if (final_beat) begin
                out_sum_d   = sum_c;
                out_bit_d   = (32'(sum_c) >= 32'(THRESH));
                out_valid_d = 1'b1;
                acc_d       = '0;
                beat_cnt_d  = '0;
            end else begin
                acc_d      = sum_c;
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            out_sum_q   <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            out_sum_q   <= out_sum_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/xnor_popcount_acc.md
# xnor_popcount_acc

Streaming popcount accumulator that sits directly downstream of the XNOR stage. It consumes the per-bit match vector produced by XNOR (one bit set per matching bit of `a`/`b`) and counts the set bits. It accumulates that count over a fixed window of beats and emits the window total plus a thresholded decision bit, XNOR-popcount style. Input and output use valid/ready handshakes.

## Interface
- `WIDTH`, 5: width of the match vector; equals the XNOR stage `WIDTH`.
- `WINDOW`, 4: number of accepted beats per result; legal range 1..255.
- `THRESH`, 10: decision threshold; `out_bit = (out_sum >= THRESH)`.
- `SUM_W`, `$clog2(WIDTH*WINDOW+1)`: derived local width of the sum; not overridable.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clear`  in  1  synchronous discard of the partial window.
- `in_valid`  in  1  `in_vec` holds a beat.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_vec`  in  WIDTH  match vector, normally XNOR `z`.
- `out_valid`  out  1  result held on `out_sum` and `out_bit`.
- `out_ready`  in  1  sink accepts the result.
- `out_sum`  out  SUM_W  total set bits over the window.
- `out_bit`  out  1  threshold decision.

## Operation
- Registered state:
  - `acc` (SUM_W bits)
  - `beat_cnt` (0..WINDOW-1)
  - output register holding `out_sum`, `out_bit` and `out_valid`
- Beat accept: `in_valid && in_ready` on a rising edge.
- Per accepted beat, `pc = popcount(in_vec)`, range 0..WIDTH, computed combinationally.
- Non-final beat (`beat_cnt < WINDOW-1`): `acc <= acc + pc`, `beat_cnt <= beat_cnt + 1`.
- Final beat (`beat_cnt == WINDOW-1`):
  - `out_sum <= acc + pc`
  - `out_bit <= (acc + pc >= THRESH)`
  - `out_valid <= 1`
  - `acc <= 0`, `beat_cnt <= 0`
- Arithmetic is unsigned. `acc + pc` never exceeds `WIDTH*WINDOW`, so no overflow and no saturation logic is needed.
- `in_ready = !(beat_cnt == WINDOW-1 && out_valid)`. It depends only on registers; there is no combinational path from `out_ready`.
- Output handshake:
  - `out_valid` clears on `out_valid && out_ready` unless a final beat is accepted in the same edge.
  - A final beat cannot be accepted while `out_valid` is high, so that collision cannot occur.
- `out_sum` and `out_bit` stay stable while `out_valid && !out_ready`.
- `clear`:
  - Forces `acc <= 0` and `beat_cnt <= 0`.
  - Has priority over a simultaneous beat accept; that beat is dropped.
  - Does not affect a pending `out_valid` result.
- `WINDOW == 1`: every beat is final. With `out_ready` tied high, throughput is one result every 2 cycles.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - `acc`, `beat_cnt`, `out_sum`, `out_bit`, `out_valid` = 0
  - `in_ready` = 1 (derived from the reset registers)
- Latency: when the final beat is accepted at edge N, `out_valid`, `out_sum` and `out_bit` are valid from edge N until the handshake.
- Throughput for `WINDOW >= 2` with `out_ready` high: one beat per cycle, no bubbles.
- Backpressure: when `out_valid` is held and `beat_cnt == WINDOW-1`, `in_ready` is low. It returns high on the cycle after the `out_ready` handshake.
- Reset mid-window or with a pending result discards everything. The next window starts from `beat_cnt` = 0.
- `in_vec` is sampled only on accept. X on `in_vec` while `in_valid` is low must not propagate to any register.

## Test plan
All scenarios use defaults: WIDTH=5, WINDOW=4, THRESH=10.
- All-match window: 4 beats of `5'b11111`, `out_ready` = 1 -> one result, `out_sum` = 20, `out_bit` = 1, `out_valid` high for exactly 1 cycle.
- Mixed window: beats `00000`, `00001`, `00011`, `00111` -> `out_sum` = 6, `out_bit` = 0. Then beats `01111`, `01111`, `00011`, `00000` -> `out_sum` = 10, `out_bit` = 1 (threshold boundary).
- Backpressure: `out_ready` = 0, stream 8 beats of `00001` with `in_valid` held high.
  - First result: `out_sum` = 4, held stable.
  - `in_ready` drops when `beat_cnt` = 3.
  - Raise `out_ready` for 1 cycle -> next cycle `in_ready` = 1; the 8th beat is accepted; second result `out_sum` = 4.
- Clear mid-window: 2 beats of `11111`, then `clear` concurrent with a third `11111` beat, then 4 beats of `00001` -> single result `out_sum` = 4. The dropped beat is not counted.
- Reset mid-operation: 3 beats of `11111` accepted, then `rst_n` pulsed low asynchronously between edges -> all outputs 0 immediately, `in_ready` = 1. The following 4 beats of `00011` yield `out_sum` = 8.
- Random soak: 200 random `in_vec` beats with random `in_valid`/`out_ready` -> every result equals a reference popcount sum per 4 accepted beats. No result is lost or duplicated.
